// File: rtl/am2950_fifo_port.sv
// rtl/am2950_fifo_port.sv - dual-queue bidirectional FIFO port between two tristate buses

// One direction's queue: show-ahead storage, level count and sticky error.
module am2950_fifo_port_q #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             cp,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic             block,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    cnt,
  output logic             ne,
  output logic             full,
  output logic             err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    hd;
  logic [AW-1:0]    tl;
  logic             do_push;
  logic             do_pop;
  logic             bad;
  logic [CW-1:0]    cnt_nxt;

  // A full queue still accepts a push when the same edge pops; the count,
  // not the pointers, decides full/empty so no ambiguity arises on wrap.
  always_comb begin
    do_pop  = pop && (cnt != '0);
    do_push = push && !block && ((cnt != FULL_CNT) || do_pop);
    bad     = (push && !do_push) || (pop && !do_pop);
    cnt_nxt = cnt;
    case ({do_push, do_pop})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  // Pointers, level, registered status flags and the sticky error.
  always_ff @(posedge cp or posedge clr) begin
    if (clr) begin
      hd   <= '0;
      tl   <= '0;
      cnt  <= '0;
      ne   <= 1'b0;
      full <= 1'b0;
      err  <= 1'b0;
    end else begin
      if (do_pop)  hd <= hd + 1'b1;
      if (do_push) tl <= tl + 1'b1;
      cnt  <= cnt_nxt;
      ne   <= (cnt_nxt != '0);
      full <= (cnt_nxt == FULL_CNT);
      if (bad) err <= 1'b1;
    end
  end

  // Storage is never cleared; reset only discards it by rewinding pointers.
  always_ff @(posedge cp) begin
    if (do_push) mem[tl] <= din;
  end

  assign head = mem[hd];
endmodule

module am2950_fifo_port #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             cp,
  input  logic             clr,
  inout  wire  [WIDTH-1:0] a,
  input  logic             wra_,
  input  logic             rda_,
  input  logic             oea_,
  inout  wire  [WIDTH-1:0] b,
  input  logic             wrb_,
  input  logic             rdb_,
  input  logic             oeb_,
  output logic             fr,
  output logic             fs,
  output logic             ffr,
  output logic             ffs,
  output logic [CW-1:0]    cntr,
  output logic [CW-1:0]    cnts,
  output logic             errr,
  output logic             errs
);
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] s_head;

  // R queue: A-side writes, B-side reads. Driving a blocks capture from a.
  am2950_fifo_port_q #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_r (
    .cp(cp), .clr(clr), .push(!wra_), .pop(!rdb_), .block(!oea_), .din(a),
    .head(r_head), .cnt(cntr), .ne(fr), .full(ffr), .err(errr)
  );

  // S queue: B-side writes, A-side reads.
  am2950_fifo_port_q #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_s (
    .cp(cp), .clr(clr), .push(!wrb_), .pop(!rda_), .block(!oeb_), .din(b),
    .head(s_head), .cnt(cnts), .ne(fs), .full(ffs), .err(errs)
  );

  // An empty queue presents zero rather than stale storage.
  assign a = oea_ ? {WIDTH{1'bz}} : (fs ? s_head : '0);
  assign b = oeb_ ? {WIDTH{1'bz}} : (fr ? r_head : '0);
endmodule

// File: tb/tb_am2950_fifo_port.sv
// tb/tb_am2950_fifo_port.sv - directed bench with queue-based reference model

module tb_am2950_fifo_port;
  localparam int D = 4;

  logic       cp = 1'b0;
  logic       clr = 1'b1;
  logic       wra_, rda_, oea_, wrb_, rdb_, oeb_;
  logic       a_en, b_en;
  logic [7:0] a_drv, b_drv;
  wire  [7:0] a, b;
  logic       fr, fs, ffr, ffs, errr, errs;
  logic [2:0] cntr, cnts;

  int vec  = 0;
  int miss = 0;

  logic [7:0] qr[$];
  logic [7:0] qs[$];
  logic       er_m, es_m;

  assign a = a_en ? a_drv : 8'bz;
  assign b = b_en ? b_drv : 8'bz;

  am2950_fifo_port dut (
    .cp(cp), .clr(clr), .a(a), .wra_(wra_), .rda_(rda_), .oea_(oea_),
    .b(b), .wrb_(wrb_), .rdb_(rdb_), .oeb_(oeb_),
    .fr(fr), .fs(fs), .ffr(ffr), .ffs(ffs),
    .cntr(cntr), .cnts(cnts), .errr(errr), .errs(errs)
  );

  always #5 cp = ~cp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: each queue as an unbounded list limited to D entries.
  always @(posedge cp or posedge clr) begin
    if (clr) begin
      qr.delete(); qs.delete();
      er_m = 1'b0; es_m = 1'b0;
    end else begin
      bit pr, ps, rr, rs;
      pr = (qr.size() > 0) && !rdb_;
      ps = (qs.size() > 0) && !rda_;
      rr = !wra_ && oea_ && (qr.size() < D || pr);
      rs = !wrb_ && oeb_ && (qs.size() < D || ps);
      if ((!wra_ && !rr) || (!rdb_ && !pr)) er_m = 1'b1;
      if ((!wrb_ && !rs) || (!rda_ && !ps)) es_m = 1'b1;
      if (pr) void'(qr.pop_front());
      if (ps) void'(qs.pop_front());
      if (rr) qr.push_back(a_drv);
      if (rs) qs.push_back(b_drv);
    end
  end

  // Every cycle outside reset: all outputs against the reference.
  always @(negedge cp) begin
    if (!clr) begin
      logic [7:0] hr, hs;
      hr = (qr.size() > 0) ? qr[0] : 8'h00;
      hs = (qs.size() > 0) ? qs[0] : 8'h00;
      chk("cntr", 32'(cntr), 32'(qr.size()));
      chk("cnts", 32'(cnts), 32'(qs.size()));
      chk("fr", 32'(fr), 32'(qr.size() != 0));
      chk("fs", 32'(fs), 32'(qs.size() != 0));
      chk("ffr", 32'(ffr), 32'(qr.size() == D));
      chk("ffs", 32'(ffs), 32'(qs.size() == D));
      chk("errr", 32'(errr), 32'(er_m));
      chk("errs", 32'(errs), 32'(es_m));
      if (!oeb_) chk("b_bus", 32'(b), 32'(hr));
      else if (b_en) chk("b_float", 32'(b), 32'(b_drv));
      if (!oea_) chk("a_bus", 32'(a), 32'(hs));
      else if (a_en) chk("a_float", 32'(a), 32'(a_drv));
    end
  end

  task automatic idle();
    wra_ = 1; rda_ = 1; oea_ = 1; wrb_ = 1; rdb_ = 1; oeb_ = 1;
    a_en = 0; b_en = 0;
  endtask

  task automatic cyc();
    @(posedge cp); @(negedge cp); #1;
  endtask

  task automatic pulse_clr();
    #2 clr = 1; #1;
    chk("rst_cntr", 32'(cntr), 0);
    chk("rst_cnts", 32'(cnts), 0);
    chk("rst_flags", {28'd0, fr, fs, ffr, ffs}, 0);
    chk("rst_err", {30'd0, errr, errs}, 0);
    #1 clr = 0; #1;
  endtask

  task automatic push_r(input logic [7:0] v);
    wra_ = 0; a_en = 1; a_drv = v; cyc(); wra_ = 1; a_en = 0;
  endtask

  logic [7:0] fill [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] seq4 [4] = '{8'h22, 8'h33, 8'h44, 8'h55};

  initial begin
    idle(); a_drv = 0; b_drv = 0;
    @(negedge cp); #1 clr = 0;
    cyc();

    // Fill and drain.
    for (int i = 0; i < 4; i++) push_r(fill[i]);
    chk("fill_cntr", 32'(cntr), 4);
    chk("fill_ffr", 32'(ffr), 1);
    oeb_ = 0; #1;
    chk("show_ahead", 32'(b), 32'h11);
    for (int i = 0; i < 4; i++) begin
      chk("drain_b", 32'(b), 32'(fill[i]));
      rdb_ = 0; cyc();
    end
    rdb_ = 1; #1;
    chk("drained_b", 32'(b), 0);
    chk("drained_fr", 32'(fr), 0);
    oeb_ = 1;

    // Overflow keeps contents intact.
    for (int i = 0; i < 4; i++) push_r(fill[i]);
    push_r(8'h99);
    chk("ovf_cntr", 32'(cntr), 4);
    chk("ovf_errr", 32'(errr), 1);
    oeb_ = 0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("ovf_data", 32'(b), 32'(fill[i]));
      rdb_ = 0; cyc();
    end
    rdb_ = 1; oeb_ = 1; cyc();

    // Mid-cycle reset; with both enables high the buses carry only bench values.
    pulse_clr();
    a_en = 1; a_drv = 8'h5A; b_en = 1; b_drv = 8'hA5; #1;
    chk("a_float", 32'(a), 32'h5A);
    chk("b_float", 32'(b), 32'hA5);
    a_en = 0; b_en = 0;

    // Underflow on R only.
    rdb_ = 0; cyc(); rdb_ = 1;
    chk("unf_errr", 32'(errr), 1);
    chk("unf_cntr", 32'(cntr), 0);
    chk("unf_errs", 32'(errs), 0);

    // Empty queue, push and pop together: push lands, pop flagged.
    pulse_clr();
    wra_ = 0; rdb_ = 0; a_en = 1; a_drv = 8'h77; cyc(); idle();
    chk("ep_cntr", 32'(cntr), 1);
    chk("ep_errr", 32'(errr), 1);
    rdb_ = 0; cyc(); rdb_ = 1;

    // Full queue, push and pop on the same edge, then wrap.
    pulse_clr();
    for (int i = 0; i < 4; i++) push_r(fill[i]);
    oeb_ = 0; wra_ = 0; a_en = 1; a_drv = 8'h55; rdb_ = 0; cyc();
    wra_ = 1; a_en = 0; rdb_ = 1;
    chk("conc_cntr", 32'(cntr), 4);
    chk("conc_errr", 32'(errr), 0);
    for (int i = 0; i < 4; i++) begin
      #1 chk("wrap_b", 32'(b), 32'(seq4[i]));
      rdb_ = 0; cyc();
    end
    idle(); cyc();

    // Both directions interleaved.
    pulse_clr();
    for (int i = 0; i < 4; i++) begin
      wra_ = 0; a_en = 1; a_drv = 8'hA0 + 8'(i);
      if (i < 3) begin wrb_ = 0; b_en = 1; b_drv = 8'hB0 + 8'(i); end
      cyc(); idle();
    end
    oea_ = 0; oeb_ = 0; #1;
    chk("bi_a", 32'(a), 32'hB0);
    chk("bi_b", 32'(b), 32'hA0);
    chk("bi_cntr", 32'(cntr), 4);
    chk("bi_cnts", 32'(cnts), 3);
    rda_ = 0; rdb_ = 0; cyc(); rda_ = 1; rdb_ = 1;
    chk("bi_a2", 32'(a), 32'hB1);
    chk("bi_b2", 32'(b), 32'hA1);

    // Conflict: push on a while the block drives a.
    wra_ = 0; cyc(); wra_ = 1;
    chk("cf_cntr", 32'(cntr), 3);
    chk("cf_errr", 32'(errr), 1);
    chk("cf_errs", 32'(errs), 0);
    chk("cf_a", 32'(a), 32'hB1);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
